// File: rtl/uart_rx_fifo.sv
// UART receiver with mid-bit sampling, false-start rejection, framing/parity checks and an output FIFO.
// Optional parity bit: define UART_RX_PARITY_EN (PARITY_ODD then selects odd/even sense).
module uart_rx_fifo #(
    parameter int CLOCK_FREQ_HZ = 12000000,
    parameter int BAUD_RATE     = 9600,
    parameter int DATA_BITS     = 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int PARITY_ODD    = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         RX,
    output logic [DATA_BITS-1:0]         out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(FIFO_DEPTH):0]  level,
    output logic                         busy,
    output logic                         frame_err,
    output logic                         parity_err,
    output logic                         overflow
);
    localparam int BIT_PERIOD = CLOCK_FREQ_HZ / BAUD_RATE;
    localparam int CW = $clog2(BIT_PERIOD);
    localparam int IW = $clog2(DATA_BITS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_PERIOD - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(BIT_PERIOD / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    generate
        if (BIT_PERIOD < 8 || DATA_BITS < 5 || DATA_BITS > 9 || FIFO_DEPTH < 2 ||
            (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
            $error("uart_rx_fifo: illegal parameter combination");
        end
    endgenerate

    logic rx_meta_reg, rxs_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_reg <= 1'b1;
            rxs_reg     <= 1'b1;
        end else begin
            rx_meta_reg <= RX;
            rxs_reg     <= rx_meta_reg;
        end
    end

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
    localparam logic PAR_SENSE = 1'(PARITY_ODD);
    logic par_bad_reg, parity_err_reg;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

    state_t               state_reg;
    logic [CW-1:0]        cnt_reg;
    logic [IW-1:0]        idx_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 busy_reg, frame_err_reg, overflow_reg;
    logic                 bit_end, stop_ok, push, pop, full, accept;

    assign bit_end = (cnt_reg == CNT_LAST);
`ifdef UART_RX_PARITY_EN
    assign stop_ok    = !par_bad_reg;
    assign parity_err = parity_err_reg;
`else
    assign stop_ok    = 1'b1;
    assign parity_err = 1'b0;
`endif
    // The word enters the FIFO on the very edge that samples a good stop bit.
    assign push = (state_reg == STOP) && bit_end && rxs_reg && stop_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            idx_reg       <= '0;
            shift_reg     <= '0;
            busy_reg      <= 1'b0;
            frame_err_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_reg    <= 1'b0;
            parity_err_reg <= 1'b0;
`endif
        end else begin
            frame_err_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_reg <= 1'b0;
`endif
            cnt_reg <= cnt_reg + 1'b1;
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (!rxs_reg) begin
                        state_reg <= START;
                        busy_reg  <= 1'b1;
                    end
                end
                START: if (cnt_reg == CNT_HALF) begin
                    cnt_reg <= '0;
                    idx_reg <= '0;
                    if (rxs_reg) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        state_reg <= DATA;
                    end
                end
                DATA: if (bit_end) begin
                    cnt_reg   <= '0;
                    shift_reg <= {rxs_reg, shift_reg[DATA_BITS-1:1]};
                    if (idx_reg == IDX_LAST) begin
                        idx_reg <= '0;
`ifdef UART_RX_PARITY_EN
                        state_reg <= PARITY;
`else
                        state_reg <= STOP;
`endif
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (bit_end) begin
                    cnt_reg     <= '0;
                    par_bad_reg <= ((^shift_reg) ^ PAR_SENSE) != rxs_reg;
                    state_reg   <= STOP;
                end
`endif
                STOP: if (bit_end) begin
                    cnt_reg <= '0;
                    if (!rxs_reg) begin
                        frame_err_reg <= 1'b1;
                        state_reg     <= BREAK;
                    end else begin
`ifdef UART_RX_PARITY_EN
                        parity_err_reg <= par_bad_reg;
`endif
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                BREAK: if (rxs_reg) begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]          level_reg;

    assign full      = (level_reg == (AW + 1)'(FIFO_DEPTH));
    assign out_valid = (level_reg != '0);
    assign pop       = out_valid && out_ready;
    // A full FIFO still takes a word when the head leaves on the same edge.
    assign accept    = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr_reg] <= shift_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            overflow_reg <= push && !accept;
            if (accept) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)    rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({accept, pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

    assign out_data  = mem[rd_ptr_reg];
    assign level     = level_reg;
    assign busy      = busy_reg;
    assign frame_err = frame_err_reg;
    assign overflow  = overflow_reg;
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with configurable data width, mid-bit sampling, false-start rejection, framing-error detection, optional parity checking and an output FIFO with a valid/ready handshake. It is the general serial-input front end for icestick designs. It sits between the FTDI RX pin and any consumer logic, such as a command decoder or LED controller, which drains received words at its own pace.

## Interface
- CLOCK_FREQ_HZ, 12000000, system clock frequency.
- BAUD_RATE, 9600, line rate; BIT_PERIOD = CLOCK_FREQ_HZ / BAUD_RATE (integer division, must be ≥ 8).
- DATA_BITS, 8, data bits per frame, legal range 5..9.
- FIFO_DEPTH, 4, output FIFO entries, power of two, ≥ 2.
- PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd.
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- RX  input  1  asynchronous serial line, idle high.
- out_data  output  DATA_BITS  FIFO head word, LSB = first received bit.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts head when out_valid && out_ready.
- level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- busy  output  1  receiver not in IDLE.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- parity_err  output  1  one-cycle pulse: parity mismatch (tied 0 when parity is compiled out).
- overflow  output  1  one-cycle pulse: completed word dropped because the FIFO was full.

## Operation
- RX passes through a 2-flop synchroniser; both flops reset to 1. All FSM decisions use the synchronised value `rxs`.
- Bit counter `cnt` spans 0..BIT_PERIOD-1. Index `idx` spans 0..DATA_BITS-1.
- IDLE: when rxs == 0, clear cnt and go to START.
- START: sample at cnt == BIT_PERIOD/2 - 1.
  - rxs == 1 is a false start: return to IDLE, with no pulse.
  - Otherwise clear cnt and idx, and go to DATA.
- DATA: sample at cnt == BIT_PERIOD-1, then clear cnt. Shift bits in LSB-first. After bit DATA_BITS-1, go to PARITY if it is compiled in, else STOP.
- PARITY: sample at cnt == BIT_PERIOD-1 and compare against the XOR of the data bits, XORed with PARITY_ODD. Then go to STOP.
- STOP: sample at cnt == BIT_PERIOD-1.
  - rxs == 0: pulse frame_err, discard the word, go to BREAK.
  - rxs == 1 with parity mismatch: pulse parity_err, discard the word, go to IDLE.
  - Otherwise push the word and go to IDLE.
- BREAK: wait for rxs == 1, then go to IDLE. A held-low line yields exactly one frame_err.
- Frame error takes precedence over parity error; only frame_err pulses.
- FIFO push:
  - Accepted if not full, or if a pop occurs in the same cycle.
  - Otherwise the word is dropped and overflow pulses.
- Pop occurs when out_valid && out_ready. Simultaneous push and pop leaves level unchanged.
- Pointers wrap modulo FIFO_DEPTH. level saturates only by construction: it never exceeds FIFO_DEPTH and never underflows.
- out_data is undefined (don't-care) when out_valid == 0.

## Timing
- Reset values:
  - State IDLE; cnt, idx, level and pointers 0.
  - out_valid, busy, frame_err, parity_err and overflow all 0.
  - Synchroniser flops 1.
- Reset mid-frame aborts the frame with no push and no pulse, and flushes the FIFO.
- RX-to-FSM latency is 2 cycles (synchroniser).
- busy rises the cycle after the FSM leaves IDLE and falls the cycle after it re-enters IDLE.
- Push happens on the stop-sample edge. out_valid is high on the next cycle, and level increments on the same edge.
- Error and overflow pulses are asserted for exactly one cycle, on the cycle after the stop-sample edge.
- The next start bit is recognised as soon as the FSM is in IDLE and rxs == 0. Back-to-back frames with a one-bit stop are supported.

## Configuration
- UART_RX_PARITY_EN
  - Defined: the PARITY state exists, frames carry one parity bit after the data bits, and parity_err is live. PARITY_ODD selects the sense.
  - Undefined: there is no PARITY state, DATA goes directly to STOP, parity_err is tied to 0, and PARITY_ODD is ignored.

## Test plan
- 12 MHz clock, 115200 baud (BIT_PERIOD 104), DATA_BITS 8, send 0x35 with out_ready = 1 → out_valid for exactly 1 cycle with out_data = 0x35; no error pulses.
- RX low for 30 cycles then high → FSM returns to IDLE; busy falls; no push and no pulses.
- Frame 0xA5 with stop bit driven low and RX held low for 3 bit times → one frame_err, level stays 0. Then 0x5A is received correctly after RX returns high.
- FIFO_DEPTH 4, out_ready = 0, send 0x01..0x05 → level = 4 and one overflow pulse on the 5th word. Then with out_ready = 1 the FIFO drains 0x01, 0x02, 0x03, 0x04 in order.
- UART_RX_PARITY_EN, PARITY_ODD 0: send 0x07 with parity bit 1 → push 0x07. Send 0x07 with parity bit 0 → parity_err pulse, no push.
- Assert rst during data bit 3 of a frame, with 2 words already queued → out_valid = 0 and level = 0 next cycle. The following clean frame 0xC3 is received correctly.
